// File: rtl/pipe_phy_rsp.sv
`default_nettype none
// ============================================================================
// pipe_phy_rsp : single-lane PIPE PHY responder (handshakes + data path)
// Rev 1.0
// ============================================================================
module pipe_phy_rsp #(
    parameter int DW       = 8,
    parameter int RST_LAT  = 16,
    parameter int DET_LAT  = 8,
    parameter int PD_LAT   = 4,
    parameter int RATE_LAT = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   i_txdata,
    input  logic [DW/8-1:0] i_txdatak,
    input  logic            i_txelecidle,
    input  logic            i_txdetectrx,
    input  logic [1:0]      i_powerdown,
    input  logic            i_rate,
    output logic [DW-1:0]   o_rxdata,
    output logic [DW/8-1:0] o_rxdatak,
    output logic            o_rxvalid,
    output logic            o_rxelecidle,
    output logic [2:0]      o_rxstatus,
    output logic            o_phystatus,
    input  logic            i_partner_present,
    input  logic [DW-1:0]   i_lnk_rx_data,
    input  logic [DW/8-1:0] i_lnk_rx_datak,
    input  logic            i_lnk_rx_idle,
    output logic [DW-1:0]   o_lnk_tx_data,
    output logic [DW/8-1:0] o_lnk_tx_datak,
    output logic            o_lnk_tx_idle
);

    localparam int KW        = DW / 8;
    localparam int c_MAX_A   = (RST_LAT > DET_LAT) ? RST_LAT : DET_LAT;
    localparam int c_MAX_B   = (PD_LAT > RATE_LAT) ? PD_LAT : RATE_LAT;
    localparam int c_MAX_LAT = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int CW        = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

    // The counter runs LAT-1 down to 0, so a latency of exactly 2**CW still fits.
    localparam logic [CW-1:0] c_RST_LD  = CW'(RST_LAT - 1);
    localparam logic [CW-1:0] c_DET_LD  = CW'(DET_LAT - 1);
    localparam logic [CW-1:0] c_PD_LD   = CW'(PD_LAT - 1);
    localparam logic [CW-1:0] c_RATE_LD = CW'(RATE_LAT - 1);

    localparam logic [1:0] c_P0      = 2'b00;
    localparam logic [1:0] c_P1      = 2'b10;
    localparam logic [2:0] c_RXS_DET = 3'b011;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IDLE = 3'd1,
        S_DET  = 3'd2,
        S_PD   = 3'd3,
        S_RATE = 3'd4,
        S_ACK  = 3'd5
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_phystatus;
    logic [2:0]      r_rxstatus;
    logic            r_det_pend;
    logic            r_pd_pend;
    logic            r_rate_pend;
    logic            r_is_det;

    logic [1:0]      r_pd_q;
    logic [1:0]      r_pd_d;
    logic            r_rate_q;
    logic            r_rate_d;
    logic            r_det_q;
    logic            r_det_d;

    logic [DW-1:0]   r_rxdata;
    logic [KW-1:0]   r_rxdatak;
    logic            r_rxvalid;
    logic            r_rxelecidle;
    logic [DW-1:0]   r_lnk_tx_data;
    logic [KW-1:0]   r_lnk_tx_datak;
    logic            r_lnk_tx_idle;

    logic            w_pd_chg;
    logic            w_rate_chg;
    logic            w_det_rise;
    logic            w_p0;

    // Request capture is free-running so a release from reset never looks like a change.
    always_ff @(posedge clk) begin
        r_pd_q   <= i_powerdown;
        r_pd_d   <= r_pd_q;
        r_rate_q <= i_rate;
        r_rate_d <= r_rate_q;
        r_det_q  <= i_txdetectrx;
        r_det_d  <= r_det_q;
    end

    assign w_pd_chg   = (r_pd_q != r_pd_d);
    assign w_rate_chg = (r_rate_q != r_rate_d);
    assign w_det_rise = r_det_q && !r_det_d && (r_pd_q == c_P1);
    assign w_p0       = (i_powerdown == c_P0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RST;
            r_cnt       <= c_RST_LD;
            r_phystatus <= 1'b1;
            r_rxstatus  <= 3'b000;
            r_det_pend  <= 1'b0;
            r_pd_pend   <= 1'b0;
            r_rate_pend <= 1'b0;
            r_is_det    <= 1'b0;
        end else begin
            r_phystatus <= 1'b0;
            r_rxstatus  <= 3'b000;
            case (r_state)
                S_RST: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt       <= r_cnt - CW'(1);
                        r_phystatus <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (r_det_pend) begin
                        r_det_pend <= 1'b0;
                        r_is_det   <= 1'b1;
                        r_cnt      <= c_DET_LD;
                        r_state    <= S_DET;
                    end else if (r_pd_pend) begin
                        r_pd_pend <= 1'b0;
                        r_is_det  <= 1'b0;
                        r_cnt     <= c_PD_LD;
                        r_state   <= S_PD;
                    end else if (r_rate_pend) begin
                        r_rate_pend <= 1'b0;
                        r_is_det    <= 1'b0;
                        r_cnt       <= c_RATE_LD;
                        r_state     <= S_RATE;
                    end
                end
                S_DET, S_PD, S_RATE: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_ACK;
                        r_phystatus <= 1'b1;
                        r_rxstatus  <= (r_is_det && i_partner_present) ? c_RXS_DET : 3'b000;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_RST;
                end
            endcase
            // New requests win over the clear issued on dispatch, so none is lost.
            if (r_state != S_RST) begin
                if (w_det_rise) r_det_pend  <= 1'b1;
                if (w_pd_chg)   r_pd_pend   <= 1'b1;
                if (w_rate_chg) r_rate_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxdata       <= '0;
            r_rxdatak      <= '0;
            r_rxvalid      <= 1'b0;
            r_rxelecidle   <= 1'b1;
            r_lnk_tx_data  <= '0;
            r_lnk_tx_datak <= '0;
            r_lnk_tx_idle  <= 1'b1;
        end else begin
            r_rxdata     <= i_lnk_rx_data;
            r_rxdatak    <= i_lnk_rx_datak;
            r_rxvalid    <= w_p0 && !i_lnk_rx_idle && (r_state != S_RST);
            r_rxelecidle <= i_lnk_rx_idle || !w_p0;
            if (w_p0 && i_txdetectrx) begin
                r_lnk_tx_data  <= r_rxdata;
                r_lnk_tx_datak <= r_rxdatak;
            end else begin
                r_lnk_tx_data  <= i_txdata;
                r_lnk_tx_datak <= i_txdatak;
            end
            r_lnk_tx_idle <= i_txelecidle || !w_p0;
        end
    end

    assign o_rxdata       = r_rxdata;
    assign o_rxdatak      = r_rxdatak;
    assign o_rxvalid      = r_rxvalid;
    assign o_rxelecidle   = r_rxelecidle;
    assign o_rxstatus     = r_rxstatus;
    assign o_phystatus    = r_phystatus;
    assign o_lnk_tx_data  = r_lnk_tx_data;
    assign o_lnk_tx_datak = r_lnk_tx_datak;
    assign o_lnk_tx_idle  = r_lnk_tx_idle;

endmodule
`default_nettype wire
